clks_ctrl: RTL

Controller for the `clks` divider block. It sequences the divider's reset and enable, selects one of the divided clocks `clk10`/`clk20`/`clk40` through a valid/ready request handshake, and switches glitch-free between them. Downstream logic receives the selected clock as a single-cycle `tick` enable in the `clk` domain rather than as a gated clock. It sits between the top-level control and the `clks` instance, and drives that instance's `rst`/`enb`.

---
 rtl/clks_ctrl_pkg.sv | 34 +++
 rtl/clks_ctrl_edge_det.sv | 22 ++
 rtl/clks_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/clks_ctrl_pkg.sv
// clks_ctrl shared types
// state encoding, source codes, source mux helper
package clks_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    RUN    = 3'd2,
    SW_OLD = 3'd3,
    SW_NEW = 3'd4
  } state_e;

  localparam logic [1:0] SEL_10  = 2'd0;
  localparam logic [1:0] SEL_20  = 2'd1;
  localparam logic [1:0] SEL_40  = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  // pick one bit of {clk40,clk20,clk10}-ordered vector
  function automatic logic pick(
    input logic [1:0] s,
    input logic [2:0] v
  );
    logic r;
    r = 1'b0;
    case (s)
      SEL_10:  r = v[0];
      SEL_20:  r = v[1];
      SEL_40:  r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clks_ctrl_edge_det.sv
// edge_det: one-register edge detector
// rise/fall compare live input against last sample
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;

  // sample the input every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= d;
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/clks_ctrl.sv
// clks_ctrl: divider sequencing and source select
// glitch-free switch, selected source as tick enable
module clks_ctrl
  import clks_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       clk10,
  input  logic       clk20,
  input  logic       clk40,
  input  logic       reqValid,
  input  logic [1:0] reqSel,
  output logic       reqReady,
  output logic       divRst,
  output logic       enbDiv,
  output logic       tick,
  output logic [1:0] sel,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] LOAD = 4'(SETTLE - 1);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [1:0] pend_q;
  logic [3:0] cnt_q;
  logic       tick_q;
  logic       err_q;

  logic [2:0] cur_v;
  logic [2:0] rise_v;
  logic [2:0] fall_v;
  logic       rise_sel;
  logic       fall_sel;
  logic       pend_cur;
  logic       req_bad;
  logic       req_sw;

  assign cur_v = {clk40, clk20, clk10};

  edge_det u_e10 (
    .clk  (clk),
    .rst  (rst),
    .d    (clk10),
    .rise (rise_v[0]),
    .fall (fall_v[0])
  );

  edge_det u_e20 (
    .clk  (clk),
    .rst  (rst),
    .d    (clk20),
    .rise (rise_v[1]),
    .fall (fall_v[1])
  );

  edge_det u_e40 (
    .clk  (clk),
    .rst  (rst),
    .d    (clk40),
    .rise (rise_v[2]),
    .fall (fall_v[2])
  );

  assign rise_sel = pick(sel_q, rise_v);
  assign fall_sel = pick(sel_q, fall_v);
  assign pend_cur = pick(pend_q, cur_v);

  assign req_bad = reqValid && (reqSel == SEL_BAD);
  assign req_sw  = reqValid && (reqSel != SEL_BAD)
                && (reqSel != sel_q);

  // control FSM; enb loss wins over everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_10;
      pend_q  <= SEL_10;
      cnt_q   <= 4'd0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      if (!enb) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= START;
            cnt_q   <= LOAD;
          end
          START: begin
            if (cnt_q == 4'd0) state_q <= RUN;
            else               cnt_q   <= cnt_q - 4'd1;
          end
          RUN: begin
            tick_q <= rise_sel & ~req_sw;
            err_q  <= req_bad;
            if (req_sw) begin
              pend_q  <= reqSel;
              state_q <= SW_OLD;
            end
          end
          SW_OLD: begin
            if (fall_sel) state_q <= SW_NEW;
          end
          SW_NEW: begin
            if (!pend_cur) begin
              sel_q   <= pend_q;
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reqReady = (state_q == RUN);
  assign divRst   = (state_q == IDLE);
  assign enbDiv   = (state_q != IDLE);
  assign busy     = (state_q == START)
                 || (state_q == SW_OLD)
                 || (state_q == SW_NEW);
  assign tick     = tick_q;
  assign err      = err_q;
  assign sel      = sel_q;

endmodule
